thermo_word_loader: RTL and testbench
=====================================

Name: thermo_word_loader

Overview:
- Upstream feeder for the nine-operand 16-bit one-count stage (operands A..I, result y).
- Accepts a stream of ones-counts (0..16) over a valid/ready handshake and converts each count to a right-aligned thermometer word (count N sets bits [N-1:0]).
- Registers nine words into a parallel bank, then presents the bank with out_valid until the downstream stage consumes it.
- Replaces the hand-loaded constant operand pattern with a sequential, handshaked source.

Parameters:
- WIDTH, 16, bit width of each thermometer word.
- NWORDS, 9, number of words per bank (fixed ports A..I; only 9 is supported).
- CW, 5, width of in_count; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; highest priority after reset.
- in_valid  input  1  in_count is valid this cycle.
- in_ready  output  1  loader can accept a count this cycle.
- in_count  input  CW  ones-count for the next word.
- out_valid  output  1  bank A..I is complete and stable.
- out_ready  input  1  downstream consumes the bank.
- A, B, C, D, E, F, G, H, I  output  WIDTH each  thermometer words 0..8, in load order.
- fill_level  output  4  number of words loaded into the current bank (0..9).
- sat_err  output  1  sticky flag: a count greater than WIDTH was received.

Behaviour:
- Reset (rst_n low, asynchronous):
  - A..I = 0, out_valid = 0, in_ready = 0 while asserted, fill_level = 0, sat_err = 0, state = FILL, write index = 0.
  - in_ready = 1 from the first clock edge after reset deasserts.
  - Reset asserted mid-fill or mid-hold discards all content immediately.
- State FILL:
  - in_ready = 1, out_valid = 0.
  - Acceptance is in_valid && in_ready at a rising edge. On acceptance, word[idx] <= therm(in_count), then idx++ and fill_level++.
  - The new word appears on its port in the cycle after acceptance (1-cycle latency).
  - On the acceptance that writes word 8 (I), transition to HOLD; out_valid = 1 in the next cycle.
- State HOLD:
  - in_ready = 0, out_valid = 1, and A..I are held stable.
  - On out_valid && out_ready: transition to FILL, idx = 0, fill_level = 0, in_ready = 1 in the next cycle.
  - A..I keep their old values until each word is overwritten. Downstream must qualify the words with out_valid.
  - out_valid stays high indefinitely until out_ready is seen (back-pressure); in_valid is ignored in HOLD.
- Conversion therm(n):
  - n = 0 gives 0.
  - 1 <= n <= WIDTH gives (1 << n) - 1.
  - n > WIDTH saturates to all-ones (16'hFFFF) and sets sat_err on that acceptance.
  - The conversion is purely combinational on in_count and registered into the bank.
- sat_err: sticky; cleared only by reset or clr.
- clr (synchronous):
  - Behaves as reset at the next edge: words zeroed, state = FILL, idx = 0, sat_err = 0, out_valid = 0.
  - clr overrides any same-cycle input acceptance or output handshake.
- No bank is dropped or double-counted: exactly nine acceptances per out handshake.
- Throughput:
  - One word per cycle in FILL.
  - Minimum bank period is 10 cycles (9 loads + 1 hold cycle with out_ready held high).
- fill_level reads 9 throughout HOLD.

Test Plan:
- Reset then load counts 5,8,4,10,14,9,6,13,3 on consecutive cycles with out_ready = 0 -> out_valid rises one cycle after the 9th acceptance. A=001F, B=00FF, C=000F, D=03FF, E=3FFF, F=01FF, G=003F, H=1FFF, I=0007 (hex); in_ready = 0; fill_level = 9.
- Hold out_ready = 0 for 20 cycles while driving in_valid = 1 with count 16 -> A..I unchanged, no acceptance, out_valid stays 1. Then pulse out_ready for 1 cycle -> next cycle out_valid = 0, in_ready = 1, fill_level = 0.
- Boundary counts 0, 16, 17, 31 loaded into A..D -> A=0000, B=FFFF, C=FFFF, D=FFFF. sat_err = 1 from the cycle after the count-17 acceptance and stays 1 through the bank handshake.
- Gapped in_valid (every third cycle) -> words land strictly in order A..I, and out_valid asserts only after the 9th accepted count.
- Assert rst_n low asynchronously (mid-clock) after 5 loads -> all outputs are 0 immediately. After release, a fresh 9-load sequence fills starting at A.
- Assert clr in the same cycle as in_valid during FILL, and separately in the same cycle as out_ready during HOLD -> in both cases the bank is zeroed, there is no acceptance or handshake, sat_err = 0, and fill_level = 0 on the next cycle.

Source files
------------

// File: rtl/thermo_word_loader_if.sv
// Bundle for the count stream (in_*) and the nine-word thermometer bank (out_*, A..I).
// Master is the upstream/downstream environment; slave is the loader.
interface thermo_word_loader_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] A, B, C, D, E, F, G, H, I;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, A, B, C, D, E, F, G, H, I
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, A, B, C, D, E, F, G, H, I
  );
endinterface

// File: rtl/thermo_word_loader.sv
// Converts a handshaked stream of ones-counts into thermometer words and
// gathers nine of them into a bank presented with out_valid/out_ready.
module thermo_word_loader #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NWORDS = 9,
  parameter int unsigned CW     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  thermo_word_loader_if.slave  bus,
  output logic [3:0]           fill_level,
  output logic                 sat_err
);

  localparam int unsigned IDXW = 4;

  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] words_q [NWORDS];
  logic [WIDTH-1:0] words_d [NWORDS];
  logic             sat_q, sat_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] therm_c;
  logic             over_c;

  // Bit i is set when count exceeds i; counts above WIDTH saturate naturally.
  always_comb begin
    therm_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      therm_c[i] = (bus.in_count > CW'(i));
    end
    over_c = (bus.in_count > CW'(WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(NWORDS); i++) words_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < int'(NWORDS); i++) words_q[i] <= words_d[i];
    end
  end

  // Next state; clr takes precedence over any same-cycle handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    for (int i = 0; i < int'(NWORDS); i++) words_d[i] = words_q[i];

    if (clr) begin
      state_d = FILL;
      idx_d   = '0;
      sat_d   = 1'b0;
      for (int i = 0; i < int'(NWORDS); i++) words_d[i] = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.in_valid && in_ready_q) begin
            for (int i = 0; i < int'(NWORDS); i++) begin
              if (idx_q == IDXW'(i)) words_d[i] = therm_c;
            end
            idx_d = idx_q + IDXW'(1);
            sat_d = sat_q | over_c;
            if (idx_q == IDXW'(NWORDS - 1)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            state_d = FILL;
            idx_d   = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end

    in_ready_d  = (state_d == FILL);
    out_valid_d = (state_d == HOLD);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.A = words_q[0];
  assign bus.B = words_q[1];
  assign bus.C = words_q[2];
  assign bus.D = words_q[3];
  assign bus.E = words_q[4];
  assign bus.F = words_q[5];
  assign bus.G = words_q[6];
  assign bus.H = words_q[7];
  assign bus.I = words_q[8];
  assign fill_level = idx_q;
  assign sat_err    = sat_q;

endmodule

// File: tb/tb_thermo_word_loader.sv
// Directed bench for thermo_word_loader with hand-computed thermometer words.
module tb_thermo_word_loader;

  logic clk;
  logic rst_n;
  logic clr;
  logic [3:0] fill_level;
  logic sat_err;
  int n_checks;
  int n_errors;

  thermo_word_loader_if #(.WIDTH(16), .CW(5)) bus ();

  thermo_word_loader #(.WIDTH(16), .NWORDS(9), .CW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .bus        (bus),
    .fill_level (fill_level),
    .sat_err    (sat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] w [9];
  assign w[0] = bus.A;
  assign w[1] = bus.B;
  assign w[2] = bus.C;
  assign w[3] = bus.D;
  assign w[4] = bus.E;
  assign w[5] = bus.F;
  assign w[6] = bus.G;
  assign w[7] = bus.H;
  assign w[8] = bus.I;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] c);
    bus.in_valid = 1'b1;
    bus.in_count = c;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_bank(input string tag, input logic [15:0] exp [9]);
    for (int k = 0; k < 9; k++) check($sformatf("%s_w%0d", tag, k), 32'(w[k]), 32'(exp[k]));
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  logic [4:0]  cnt1 [9] = '{5'd5, 5'd8, 5'd4, 5'd10, 5'd14, 5'd9, 5'd6, 5'd13, 5'd3};
  logic [15:0] exp1 [9] = '{16'h001F, 16'h00FF, 16'h000F, 16'h03FF, 16'h3FFF,
                            16'h01FF, 16'h003F, 16'h1FFF, 16'h0007};
  logic [4:0]  cnt2 [9] = '{5'd0, 5'd16, 5'd17, 5'd31, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
  logic [15:0] exp2 [9] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001,
                            16'h0003, 16'h0007, 16'h000F, 16'h001F};
  logic [15:0] exp3 [9] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F,
                            16'h003F, 16'h007F, 16'h00FF, 16'h01FF};
  logic [15:0] exp4 [9] = '{16'h01FF, 16'h00FF, 16'h007F, 16'h003F, 16'h001F,
                            16'h000F, 16'h0007, 16'h0003, 16'h0001};
  logic [15:0] zero9 [9] = '{default: 16'h0000};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_count = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_fill", 32'(fill_level), 0);
    check("rst_sat", 32'(sat_err), 0);
    check_bank("rst", zero9);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Back-to-back load of nine counts
    for (int k = 0; k < 9; k++) begin
      load(cnt1[k]);
      check($sformatf("t1_lat_w%0d", k), 32'(w[k]), 32'(exp1[k]));
      check($sformatf("t1_ov_%0d", k), 32'(bus.out_valid), (k == 8) ? 1 : 0);
      check($sformatf("t1_fill_%0d", k), 32'(fill_level), 32'(k + 1));
    end
    check_bank("t1", exp1);
    check("t1_in_ready", 32'(bus.in_ready), 0);

    // Back-pressure: in_valid ignored while holding
    bus.in_valid = 1'b1;
    bus.in_count = 5'd16;
    for (int k = 0; k < 20; k++) tick();
    check("t2_out_valid", 32'(bus.out_valid), 1);
    check("t2_fill", 32'(fill_level), 9);
    check_bank("t2", exp1);
    handshake();
    bus.in_valid = 1'b0;
    check("t2_hs_out_valid", 32'(bus.out_valid), 0);
    check("t2_hs_in_ready", 32'(bus.in_ready), 1);
    check("t2_hs_fill", 32'(fill_level), 0);
    check("t2_hs_A_kept", 32'(bus.A), 32'h001F);

    // Boundary counts and sticky saturation flag
    for (int k = 0; k < 9; k++) begin
      load(cnt2[k]);
      if (k == 1) check("t3_sat_before", 32'(sat_err), 0);
      if (k == 2) check("t3_sat_after", 32'(sat_err), 1);
    end
    check_bank("t3", exp2);
    check("t3_out_valid", 32'(bus.out_valid), 1);
    handshake();
    check("t3_sat_sticky", 32'(sat_err), 1);
    check("t3_hs_out_valid", 32'(bus.out_valid), 0);

    // Gapped input every third cycle
    for (int k = 0; k < 9; k++) begin
      load(5'(k + 1));
      check($sformatf("t4_fill_%0d", k), 32'(fill_level), 32'(k + 1));
      check($sformatf("t4_ov_%0d", k), 32'(bus.out_valid), (k == 8) ? 1 : 0);
      tick();
      tick();
    end
    check_bank("t4", exp3);
    handshake();

    // Asynchronous reset mid-fill
    for (int k = 0; k < 5; k++) load(5'd2);
    check("t5_fill_pre", 32'(fill_level), 5);
    #3;
    rst_n = 1'b0;
    #1;
    check_bank("t5_rst", zero9);
    check("t5_fill", 32'(fill_level), 0);
    check("t5_sat", 32'(sat_err), 0);
    check("t5_in_ready", 32'(bus.in_ready), 0);
    check("t5_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) load(5'(9 - k));
    check_bank("t5", exp4);
    check("t5_out_valid_full", 32'(bus.out_valid), 1);
    handshake();

    // clr during FILL with same-cycle in_valid
    load(5'd20);
    load(5'd3);
    check("t6_sat_set", 32'(sat_err), 1);
    check("t6_fill_pre", 32'(fill_level), 2);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_count = 5'd15;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    check_bank("t6_fill_clr", zero9);
    check("t6_fill", 32'(fill_level), 0);
    check("t6_sat", 32'(sat_err), 0);
    check("t6_in_ready", 32'(bus.in_ready), 1);

    // clr during HOLD with same-cycle out_ready
    for (int k = 0; k < 9; k++) load(5'd1);
    check("t7_out_valid_pre", 32'(bus.out_valid), 1);
    check("t7_I_pre", 32'(bus.I), 32'h0001);
    clr = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    clr = 1'b0;
    bus.out_ready = 1'b0;
    check_bank("t7_hold_clr", zero9);
    check("t7_out_valid", 32'(bus.out_valid), 0);
    check("t7_fill", 32'(fill_level), 0);
    check("t7_sat", 32'(sat_err), 0);
    check("t7_in_ready", 32'(bus.in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
